// File: rtl/redux_ctrl_if.sv
// -----------------------------------------------------------------------------
// redux_ctrl_if
// Bundle of signals between the ReduxV control unit and the datapath/memory
// around it.
//
//   master : the control unit (consumes memory/ALU status, drives strobes)
//   slave  : the datapath side (drives memory/ALU status, consumes strobes)
//
// Signals
//   mem_rdata  8    memory read data (instruction or load data)
//   mem_ready  1    memory access complete this cycle
//   zero       1    ALU zero flag (operand A == 0)
//   mem_rd     1    memory read request
//   mem_wr     1    memory write request
//   addr_sel   1    0 = address from PC, 1 = address from R[rb]
//   pc_en      1    PC load enable
//   pc_sel     1    0 = PC+1, 1 = R[rb]
//   reg_wr     1    register file write to R[ra]
//   wb_sel     1    0 = ALU result, 1 = mem_rdata
//   alu_op     4    ALU operation code
//   ra_idx     2    IR[3:2]
//   rb_idx     2    IR[1:0]
//   ir         IW   latched instruction
//   halted     1    core halted
// -----------------------------------------------------------------------------
interface redux_ctrl_if #(
   parameter int IW = 8
);
   logic [7:0]    mem_rdata;
   logic          mem_ready;
   logic          zero;
   logic          mem_rd;
   logic          mem_wr;
   logic          addr_sel;
   logic          pc_en;
   logic          pc_sel;
   logic          reg_wr;
   logic          wb_sel;
   logic [3:0]    alu_op;
   logic [1:0]    ra_idx;
   logic [1:0]    rb_idx;
   logic [IW-1:0] ir;
   logic          halted;

   modport master (
      input  mem_rdata, mem_ready, zero,
      output mem_rd, mem_wr, addr_sel, pc_en, pc_sel, reg_wr, wb_sel,
             alu_op, ra_idx, rb_idx, ir, halted
   );

   modport slave (
      output mem_rdata, mem_ready, zero,
      input  mem_rd, mem_wr, addr_sel, pc_en, pc_sel, reg_wr, wb_sel,
             alu_op, ra_idx, rb_idx, ir, halted
   );
endinterface

// File: rtl/redux_ctrl.sv
// -----------------------------------------------------------------------------
// redux_ctrl
// Multi-cycle control unit for the 8-bit ReduxV core. Fetches and latches one
// instruction at a time, decodes it and sequences PC, register file, memory
// and writeback. Sits directly upstream of the ALU.
//
// Ports
//   clk  in   rising-edge clock
//   rst  in   asynchronous reset, active-high
//   bus  master modport of redux_ctrl_if (memory/ALU status in, strobes,
//        ALU op, register indices, ir and halted out)
//
// Only the state and the instruction register are stored; every strobe is a
// combinational function of state, ir, mem_ready and zero.
// -----------------------------------------------------------------------------
module redux_ctrl #(
   parameter int            IW       = 8,
   parameter logic [IW-1:0] RESET_IR = 8'h00
) (
   input  logic         clk,
   input  logic         rst,
   redux_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_BRZR = 4'h0;
   localparam logic [3:0] OP_LD   = 4'h1;
   localparam logic [3:0] OP_ST   = 4'h2;
   localparam logic [3:0] OP_HALT = 4'hD;

   state_t        state, state_nxt;
   logic [IW-1:0] ir_q;
   logic          ir_ld;
   logic [3:0]    opcode;

   logic mem_rd_c, mem_wr_c, addr_sel_c, pc_en_c, pc_sel_c;
   logic reg_wr_c, wb_sel_c, halted_c;

   assign opcode = ir_q[IW-1 -: 4];

   // ALU op mapping; opcodes without an ALU function drive 0000.
   function automatic logic [3:0] alu_map(input logic [3:0] op);
      logic [3:0] r;
      case (op)
         4'h3:    r = 4'b0000;
         4'h4:    r = 4'b0001;
         4'h5:    r = 4'b0010;
         4'h6:    r = 4'b0011;
         4'h7:    r = 4'b0100;
         4'h8:    r = 4'b0101;
         4'h9:    r = 4'b0110;
         4'hA:    r = 4'b0111;
         4'hB:    r = 4'b1100;
         4'hC:    r = 4'b1110;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   // State and instruction register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         ir_q  <= RESET_IR;
      end else begin
         state <= state_nxt;
         if (ir_ld)
            ir_q <= bus.mem_rdata[IW-1:0];
      end
   end

   // Next state and strobes.
   always_comb begin
      state_nxt  = state;
      ir_ld      = 1'b0;
      mem_rd_c   = 1'b0;
      mem_wr_c   = 1'b0;
      addr_sel_c = 1'b0;
      pc_en_c    = 1'b0;
      pc_sel_c   = 1'b0;
      reg_wr_c   = 1'b0;
      wb_sel_c   = 1'b0;
      halted_c   = 1'b0;

      case (state)
         FETCH: begin
            mem_rd_c = 1'b1;
            if (bus.mem_ready) begin
               ir_ld     = 1'b1;
               pc_en_c   = 1'b1;
               state_nxt = DECODE;
            end
         end

         // Register file read settles; nothing is driven.
         DECODE: state_nxt = EXEC;

         EXEC: begin
            case (opcode)
               OP_BRZR: begin
                  if (bus.zero) begin
                     pc_en_c  = 1'b1;
                     pc_sel_c = 1'b1;
                  end
                  state_nxt = FETCH;
               end
               OP_LD, OP_ST: state_nxt = MEM;
               OP_HALT:      state_nxt = HALT;
               4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC: begin
                  reg_wr_c  = 1'b1;
                  state_nxt = FETCH;
               end
               // Reserved opcodes retire as nop.
               default: state_nxt = FETCH;
            endcase
         end

         // Only ld and st ever reach MEM.
         MEM: begin
            addr_sel_c = 1'b1;
            if (opcode == OP_ST) begin
               mem_wr_c = 1'b1;
            end else begin
               mem_rd_c = 1'b1;
               if (bus.mem_ready) begin
                  reg_wr_c = 1'b1;
                  wb_sel_c = 1'b1;
               end
            end
            if (bus.mem_ready)
               state_nxt = FETCH;
         end

         HALT: halted_c = 1'b1;

         default: state_nxt = FETCH;
      endcase

      // Reset is asynchronous, so outputs must be quiet while it is held,
      // not just after the next edge.
      if (rst) begin
         ir_ld      = 1'b0;
         mem_rd_c   = 1'b0;
         mem_wr_c   = 1'b0;
         addr_sel_c = 1'b0;
         pc_en_c    = 1'b0;
         pc_sel_c   = 1'b0;
         reg_wr_c   = 1'b0;
         wb_sel_c   = 1'b0;
         halted_c   = 1'b0;
      end
   end

   assign bus.mem_rd   = mem_rd_c;
   assign bus.mem_wr   = mem_wr_c;
   assign bus.addr_sel = addr_sel_c;
   assign bus.pc_en    = pc_en_c;
   assign bus.pc_sel   = pc_sel_c;
   assign bus.reg_wr   = reg_wr_c;
   assign bus.wb_sel   = wb_sel_c;
   assign bus.halted   = halted_c;
   assign bus.alu_op   = alu_map(opcode);
   assign bus.ra_idx   = ir_q[3:2];
   assign bus.rb_idx   = ir_q[1:0];
   assign bus.ir       = ir_q;

endmodule

// File: doc/redux_ctrl.md
Name: redux_ctrl

Overview:
- Multi-cycle control unit for the 8-bit ReduxV core. It sits directly upstream of the ALU.
- Fetches and latches the instruction, decodes it, and sequences PC, register file, memory and writeback.
- Drives the ALU 4-bit op code and consumes the ALU zero flag (zero = operand A is 0) for the conditional branch.
- One instruction is in flight at a time. There is no pipelining.

Parameters:
- IW, 8, instruction width. Fixed format: opcode[7:4], ra[3:2], rb[1:0].
- RESET_IR, 8'h00, instruction register value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_rdata  in  8  memory read data (instruction or load data).
- mem_ready  in  1  memory access complete this cycle.
- zero  in  1  ALU zero flag (operand A == 0).
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- addr_sel  out  1  0 = address from PC, 1 = address from R[rb].
- pc_en  out  1  PC load enable.
- pc_sel  out  1  0 = PC+1, 1 = R[rb] (branch target).
- reg_wr  out  1  register file write to R[ra].
- wb_sel  out  1  0 = ALU result, 1 = mem_rdata.
- alu_op  out  4  ALU operation code.
- ra_idx  out  2  IR[3:2].
- rb_idx  out  2  IR[1:0].
- ir  out  8  latched instruction.
- halted  out  1  core halted.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, HALT.
- Reset (async, any state, including mid memory access): state = FETCH, ir = RESET_IR. All strobes (mem_rd, mem_wr, pc_en, reg_wr) are 0 while rst is high. halted = 0.
- Opcodes:
  - 0 = brzr: if R[ra]==0, PC = R[rb].
  - 1 = ld: R[ra] = M[R[rb]].
  - 2 = st: M[R[rb]] = R[ra].
  - 3 = not, alu 0000.
  - 4 = and, alu 0001.
  - 5 = or, alu 0010.
  - 6 = xor, alu 0011.
  - 7 = add, alu 0100.
  - 8 = sub, alu 0101.
  - 9 = slr, alu 0110.
  - A = srr, alu 0111.
  - B = inc (R[rb]+1), alu 1100.
  - C = slf (R[rb]<<4), alu 1110.
  - D = halt.
  - E, F = reserved, executed as nop.
- alu_op is combinational from ir. Opcodes with no ALU mapping drive 0000. ra_idx and rb_idx are always IR fields.
- Strobes are combinational from state, ir, mem_ready and zero. Only state and ir are registered.
- FETCH:
  - Drive addr_sel=0, mem_rd=1.
  - While mem_ready=0: hold the state, with no other strobes.
  - On mem_ready=1: ir <= mem_rdata, pc_en=1, pc_sel=0, next state DECODE.
- DECODE: all strobes 0 (register file read settles). Next state EXEC.
- EXEC, by opcode:
  - ALU ops 3..C: reg_wr=1, wb_sel=0, next FETCH.
  - brzr: if zero=1, pc_en=1 and pc_sel=1; if zero=0, no strobe. Next FETCH.
  - ld/st: no strobe, next MEM.
  - halt: next HALT.
  - reserved: no strobe, next FETCH.
- MEM, ld: addr_sel=1, mem_rd=1. Wait for mem_ready. In the cycle mem_ready=1, reg_wr=1 and wb_sel=1. Next FETCH.
- MEM, st: addr_sel=1, mem_wr=1 held until mem_ready=1. Next FETCH.
- mem_rd and mem_wr are never both 1.
- HALT: halted=1, all strobes 0, remain until rst.
- mem_ready asserted outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - ALU/brzr/reserved: 3 cycles (FETCH, DECODE, EXEC).
  - ld/st: 4 cycles.
  - Each wait cycle adds 1.
- Only one write per instruction: reg_wr and mem_wr are mutually exclusive. pc_en fires at most twice per instruction (fetch increment, then taken branch).

Test Plan:
- Reset then zero-wait fetch of 8'h74 (add r1,r0):
  - fetch: pc_en=1/pc_sel=0 on cycle 1.
  - DECODE on cycle 2.
  - EXEC: reg_wr=1, wb_sel=0, alu_op=0100, ra_idx=1, rb_idx=0.
  - Back to FETCH on cycle 4.
- brzr 8'h06 with zero=1 -> EXEC pc_en=1, pc_sel=1. Repeat with zero=0 -> pc_en=0 in EXEC.
- ld 8'h1B with mem_ready low 2 cycles in MEM:
  - mem_rd=1, addr_sel=1 for 3 cycles.
  - reg_wr=1, wb_sel=1 only in the ready cycle.
  - Total 6 cycles.
- st 8'h2E zero-wait -> mem_wr=1 for exactly one cycle in MEM, reg_wr never 1, mem_rd=0 in MEM.
- Opcode decode: 8'hB1 -> alu_op=1100. 8'hC2 -> alu_op=1110. 8'hE0 -> no strobes in EXEC, returns to FETCH.
- 8'hD0 -> halted=1, all strobes 0 for 10 cycles with mem_ready toggling. Assert rst mid-MEM of a ld -> state FETCH and ir=00 immediately, with no reg_wr.
